dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 51, words of attached data memory; word index = addr[13:2].
REQ-002 Parameter MAX_WAIT, default 3, consecutive aux-loss cycles before aux is forced priority.
REQ-003 Port clk  in  1  system clock; all state updates on posedge clk.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports c_req/c_we  in  1 each  CPU request / write-enable.
REQ-006 Ports c_addr/c_wd  in  32 each  CPU byte address / write data.
REQ-007 Ports c_ack  out  1, c_rd  out  32, c_err  out  1  CPU completion pulse, read data, range error.
REQ-008 Ports x_req, x_we, x_addr, x_wd, x_ack, x_rd, x_err  aux-port equivalents, same widths and directions as the CPU port.
REQ-009 Ports m_we  out  1, m_a  out  32, m_wd  out  32  memory-side write-enable, address, write data.
REQ-010 Port m_rd  in  32  memory combinational read data.
REQ-011 Port busy  out  1  high while state is ACK.

Function
REQ-012 FSM states IDLE and ACK only; IDLE->ACK when any request is granted; ACK->IDLE unconditionally.
REQ-013 No grant is issued in ACK; max throughput is one access per 2 cycles.
REQ-014 In IDLE, grant CPU if c_req, unless wait_cnt==MAX_WAIT and x_req, in which case grant aux; otherwise grant aux if x_req.
REQ-015 m_a, m_wd are driven combinationally from the granted port in the grant cycle; m_we = granted *_we in that cycle, else 0.
REQ-016 m_a, m_wd are 0 and m_we is 0 when no grant (IDLE without requests, or ACK).
REQ-017 At the posedge ending the grant cycle, m_rd is registered into the granted port's *_rd; the other port's *_rd holds.
REQ-018 The granted port's *_ack is high for exactly the ACK cycle; never both acks in one cycle.
REQ-019 Requesters hold req/we/addr/wd stable until ack; a req still high in the ACK cycle is serviced as a new request from the next IDLE.
REQ-020 wait_cnt increments (saturating at MAX_WAIT) on each grant to CPU while x_req is high; clears on grant to aux or when x_req is low in IDLE.
REQ-021 Writes: *_rd is loaded with m_rd as for reads (old word); requesters ignore it.

Reset
REQ-022 On reset: state IDLE, c_ack/x_ack 0, c_rd/x_rd 0, c_err/x_err 0, wait_cnt 0, busy 0.
REQ-023 Reset during a grant cycle forces m_we 0 in that cycle; no access is performed and no ack is issued.

Configuration
REQ-024 Macro DMEM_ARBITER_RANGE_CHK_EN: when defined, a grant with addr[13:2] >= MEM_WORDS forces m_we 0, loads *_rd with 0, and pulses *_err with *_ack.
REQ-025 Without DMEM_ARBITER_RANGE_CHK_EN, addresses pass unchecked and c_err/x_err are tied 0.

Structure
REQ-026 Package dmem_arb_pkg holds the state enum (IDLE, ACK), the port-id enum (PORT_CPU, PORT_AUX) and the default constants MEM_WORDS_DEF=51 and MAX_WAIT_DEF=3.
REQ-027 One sub-module, dmem_arb_prio: combinational grant select plus the wait_cnt register; FSM and data registers stay in dmem_arbiter.

Verification
REQ-028 CPU-only read: c_req with c_addr=0x8 and mem[2]=0xDEADBEEF -> m_we=0, m_a=0x8; next cycle c_ack=1, c_rd=0xDEADBEEF, busy=1.
REQ-029 Aux write: x_req, x_we, x_addr=0xC, x_wd=0x1234 -> m_we=1 for one cycle; next cycle x_ack=1; a later read of 0xC returns 0x1234.
REQ-030 Contention: both req held continuously -> grant order CPU,CPU,CPU,AUX,CPU,... (aux granted after 3 CPU wins); acks alternate per REQ-018.
REQ-031 Range: with DMEM_ARBITER_RANGE_CHK_EN, c_we=1, c_addr=0xCC (word 51) -> m_we=0; c_ack=1, c_err=1, c_rd=0; without the macro m_we=1 and c_err=0.
REQ-032 Reset mid-access: reset asserted in the grant cycle of a write -> m_we=0; next cycle all acks 0, state IDLE, memory unchanged.
REQ-033 Back-to-back: c_req held through ack -> second grant occurs in the cycle after ACK, giving one access per 2 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The optional range check is enabled by defining DMEM_ARBITER_RANGE_CHK_EN.
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_e;

  localparam int MEM_WORDS_DEF = 51;
  localparam int MAX_WAIT_DEF  = 3;

  // True when the byte address selects a word beyond the attached memory.
  function automatic logic word_out_of_range(input logic [31:0] addr, input int words);
    return ({20'd0, addr[13:2]} >= 32'(words));
  endfunction

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant selection between the CPU and aux ports, with a starvation counter
// that forces an aux grant after MAX_WAIT consecutive CPU wins under contention.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_idle,
  input  logic i_c_req,
  input  logic i_x_req,
  output logic o_grant,
  output logic o_gport
);

  localparam int            WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  logic [WW-1:0] r_wait_cnt;
  logic          w_aux_forced;

  // Grant decision: CPU first unless aux has waited long enough; only while idle.
  always_comb begin
    w_aux_forced = (r_wait_cnt == WAIT_SAT) && i_x_req;
    o_grant      = 1'b0;
    o_gport      = PORT_CPU;
    if (i_idle) begin
      if (i_c_req && !w_aux_forced) begin
        o_grant = 1'b1;
        o_gport = PORT_CPU;
      end else if (i_x_req) begin
        o_grant = 1'b1;
        o_gport = PORT_AUX;
      end else begin
        o_grant = 1'b0;
        o_gport = PORT_CPU;
      end
    end else begin
      o_grant = 1'b0;
      o_gport = PORT_CPU;
    end
  end

  // Count consecutive CPU wins while aux is waiting; saturate at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= {WW{1'b0}};
    end else if (i_idle) begin
      if (!i_x_req) begin
        r_wait_cnt <= {WW{1'b0}};
      end else if (o_grant && (o_gport == PORT_AUX)) begin
        r_wait_cnt <= {WW{1'b0}};
      end else if (o_grant && (r_wait_cnt != WAIT_SAT)) begin
        r_wait_cnt <= r_wait_cnt + {{(WW-1){1'b0}}, 1'b1};
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / aux) arbiter in front of a single-ported data memory.
// One access per two cycles: grant cycle (IDLE) then acknowledge cycle (ACK).
// Optional feature macro: DMEM_ARBITER_RANGE_CHK_EN (out-of-range words raise *_err).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wd,
  output logic        c_ack,
  output logic [31:0] c_rd,
  output logic        c_err,
  input  logic        x_req,
  input  logic        x_we,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wd,
  output logic        x_ack,
  output logic [31:0] x_rd,
  output logic        x_err,
  output logic        m_we,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  input  logic [31:0] m_rd,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_ACK  = ACK;

  // A word index is 12 bits wide, so larger memories cannot be addressed.
  if (MEM_WORDS < 1 || MEM_WORDS > 4096) begin : g_bad_mem_words
    $error("dmem_arbiter: MEM_WORDS must be within 1..4096");
  end

  logic [0:0]  r_state;
  logic        r_c_ack, r_x_ack, r_c_err, r_x_err;
  logic [31:0] r_c_rd, r_x_rd;

  logic        w_grant, w_gport, w_sel_we, w_oob;
  logic [31:0] w_sel_addr, w_sel_wd, w_load;

  dmem_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk     (clk),
    .reset   (reset),
    .i_idle  (r_state == ST_IDLE),
    .i_c_req (c_req),
    .i_x_req (x_req),
    .o_grant (w_grant),
    .o_gport (w_gport)
  );

  // Route the granted port onto the memory bus; bus is quiet without a grant.
  always_comb begin
    if (w_gport == PORT_AUX) begin
      w_sel_we   = x_we;
      w_sel_addr = x_addr;
      w_sel_wd   = x_wd;
    end else begin
      w_sel_we   = c_we;
      w_sel_addr = c_addr;
      w_sel_wd   = c_wd;
    end
`ifdef DMEM_ARBITER_RANGE_CHK_EN
    w_oob = word_out_of_range(w_sel_addr, MEM_WORDS);
`else
    w_oob = 1'b0;
`endif
    w_load = w_oob ? 32'd0 : m_rd;
    if (w_grant) begin
      m_a  = w_sel_addr;
      m_wd = w_sel_wd;
      m_we = w_sel_we && !w_oob && !reset;
    end else begin
      m_a  = 32'd0;
      m_wd = 32'd0;
      m_we = 1'b0;
    end
  end

  // FSM plus per-port ack/read-data/error registers; ack and err last one ACK cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_c_ack <= 1'b0;
      r_x_ack <= 1'b0;
      r_c_err <= 1'b0;
      r_x_err <= 1'b0;
      r_c_rd  <= 32'd0;
      r_x_rd  <= 32'd0;
    end else if ((r_state == ST_IDLE) && w_grant) begin
      r_state <= ST_ACK;
      r_c_ack <= (w_gport == PORT_CPU);
      r_x_ack <= (w_gport == PORT_AUX);
      r_c_err <= (w_gport == PORT_CPU) && w_oob;
      r_x_err <= (w_gport == PORT_AUX) && w_oob;
      r_c_rd  <= (w_gport == PORT_CPU) ? w_load : r_c_rd;
      r_x_rd  <= (w_gport == PORT_AUX) ? w_load : r_x_rd;
    end else begin
      r_state <= ST_IDLE;
      r_c_ack <= 1'b0;
      r_x_ack <= 1'b0;
      r_c_err <= 1'b0;
      r_x_err <= 1'b0;
      r_c_rd  <= r_c_rd;
      r_x_rd  <= r_x_rd;
    end
  end

  assign c_ack = r_c_ack;
  assign x_ack = r_x_ack;
  assign c_rd  = r_c_rd;
  assign x_rd  = r_x_rd;
  assign c_err = r_c_err;
  assign x_err = r_x_err;
  assign busy  = (r_state == ST_ACK);

endmodule
